ninjakun_outp: RTL

//  Write-side I/O block for the dual-CPU board: the output counterpart to the shared input ports.
//  - Decodes writes from CPU0 and CPU1 into these functions:
//    - flip-screen and coin lockout latches.
//    - a stretched coin-counter pulse generator.
//    - a pair of one-byte mailboxes with full/overrun flags and IRQ generation.

---
 rtl/ninjakun_outp_pkg.sv | 21 ++
 rtl/ninjakun_outp_if.sv | 30 +++
 rtl/ninjakun_coin_pulse.sv | 71 +++++++
 rtl/ninjakun_outp.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ninjakun_outp_pkg.sv
// Shared definitions for the ninjakun write-side I/O block:
// port addresses, status bit positions and the coin pulse FSM states.
package ninjakun_outp_pkg;

    localparam logic [1:0] AD_CTRL = 2'd0;
    localparam logic [1:0] AD_COIN = 2'd1;
    localparam logic [1:0] AD_MBOX = 2'd2;
    localparam logic [1:0] AD_IRQ  = 2'd3;

    localparam int ST_FULL_IN  = 0;
    localparam int ST_FULL_OUT = 1;
    localparam int ST_OVR      = 2;
    localparam int ST_IEN      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } coin_state_t;

endpackage

// File: rtl/ninjakun_outp_if.sv
// CPU-side bus bundle for both CPUs: address/data/strobes going in,
// mailbox bytes, status bytes and interrupt requests coming back.
interface ninjakun_outp_if;

    logic [1:0] AD0;
    logic [7:0] OD0;
    logic       WR0;
    logic       RD0;
    logic [1:0] AD1;
    logic [7:0] OD1;
    logic       WR1;
    logic       RD1;
    logic [7:0] MBX0;
    logic [7:0] MBX1;
    logic [7:0] STAT0;
    logic [7:0] STAT1;
    logic       IRQ0;
    logic       IRQ1;

    modport master (
        output AD0, OD0, WR0, RD0, AD1, OD1, WR1, RD1,
        input  MBX0, MBX1, STAT0, STAT1, IRQ0, IRQ1
    );

    modport slave (
        input  AD0, OD0, WR0, RD0, AD1, OD1, WR1, RD1,
        output MBX0, MBX1, STAT0, STAT1, IRQ0, IRQ1
    );

endinterface

// File: rtl/ninjakun_coin_pulse.sv
// One coin counter driver: stretches a single-cycle trigger into a pulse
// of COIN_PULSE cycles high followed by a COIN_PULSE-cycle low gap, with
// room to remember exactly one trigger that arrives while busy.
module ninjakun_coin_pulse
    import ninjakun_outp_pkg::*;
#(
    parameter int COIN_PULSE = 16,
    parameter int CPW        = 16
) (
    input  logic OUTCL,
    input  logic RESET,
    input  logic trig,
    output logic coin
);

    localparam logic [CPW-1:0] LOAD = CPW'(COIN_PULSE - 1);

    coin_state_t    state;
    logic [CPW-1:0] cnt;
    logic           pend;

    // Pulse sequencer; a trigger landing on the last gap cycle restarts the pulse directly.
    always_ff @(posedge OUTCL or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            coin  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= ON;
                        cnt   <= LOAD;
                        coin  <= 1'b1;
                    end
                end
                ON: begin
                    if (trig) pend <= 1'b1;
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= LOAD;
                        coin  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        if (pend || trig) begin
                            state <= ON;
                            cnt   <= LOAD;
                            pend  <= 1'b0;
                            coin  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (trig) pend <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    coin  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ninjakun_outp.sv
// Write-side I/O block for the dual-CPU board: control latches, coin
// counter pulses and a pair of one-byte mailboxes with status and IRQ.
// Build option: define NINJAKUN_OUTP_OVERRUN_EN to add the mailbox
// overrun flags (status bit 2, cleared by bit 7 of an IRQ-port write).
module ninjakun_outp
    import ninjakun_outp_pkg::*;
#(
    parameter int COIN_PULSE = 16,
    parameter int CPW        = 16
) (
    input  logic            OUTCL,
    input  logic            RESET,
    ninjakun_outp_if.slave  bus,
    output logic            FLIP,
    output logic [1:0]      LOCKOUT,
    output logic [1:0]      COIN
);

    logic       wr0_ctrl, wr0_coin, wr0_mbox, wr0_irq;
    logic       wr1_mbox, wr1_irq;
    logic [7:0] mbx0, mbx1;
    logic       full0, full1;
    logic       ovr0, ovr1;
    logic       ie0, ie1;
    logic [7:0] stat0, stat1;

    assign wr0_ctrl = bus.WR0 && (bus.AD0 == AD_CTRL);
    assign wr0_coin = bus.WR0 && (bus.AD0 == AD_COIN);
    assign wr0_mbox = bus.WR0 && (bus.AD0 == AD_MBOX);
    assign wr0_irq  = bus.WR0 && (bus.AD0 == AD_IRQ);
    assign wr1_mbox = bus.WR1 && (bus.AD1 == AD_MBOX);
    assign wr1_irq  = bus.WR1 && (bus.AD1 == AD_IRQ);

    // Screen flip and coin lockout latches, writable only by CPU0.
    always_ff @(posedge OUTCL or posedge RESET) begin
        if (RESET) begin
            FLIP    <= 1'b0;
            LOCKOUT <= 2'b00;
        end else if (wr0_ctrl) begin
            FLIP    <= bus.OD0[0];
            LOCKOUT <= bus.OD0[3:2];
        end
    end

    // Mailbox into CPU1, written by CPU0; a write beats a same-edge read.
    always_ff @(posedge OUTCL or posedge RESET) begin
        if (RESET) begin
            mbx1  <= 8'h00;
            full1 <= 1'b0;
        end else if (wr0_mbox) begin
            mbx1  <= bus.OD0;
            full1 <= 1'b1;
        end else if (bus.RD1) begin
            full1 <= 1'b0;
        end
    end

    // Mailbox into CPU0, written by CPU1; a write beats a same-edge read.
    always_ff @(posedge OUTCL or posedge RESET) begin
        if (RESET) begin
            mbx0  <= 8'h00;
            full0 <= 1'b0;
        end else if (wr1_mbox) begin
            mbx0  <= bus.OD1;
            full0 <= 1'b1;
        end else if (bus.RD0) begin
            full0 <= 1'b0;
        end
    end

    // Per-CPU interrupt enables from the IRQ port.
    always_ff @(posedge OUTCL or posedge RESET) begin
        if (RESET) begin
            ie0 <= 1'b0;
            ie1 <= 1'b0;
        end else begin
            if (wr0_irq) ie0 <= bus.OD0[0];
            if (wr1_irq) ie1 <= bus.OD1[0];
        end
    end

`ifdef NINJAKUN_OUTP_OVERRUN_EN
    // Overrun is raised only by a write into an unread mailbox with no read on the same edge.
    always_ff @(posedge OUTCL or posedge RESET) begin
        if (RESET) begin
            ovr0 <= 1'b0;
            ovr1 <= 1'b0;
        end else begin
            if (wr1_mbox && full0 && !bus.RD0) ovr0 <= 1'b1;
            else if (wr0_irq && bus.OD0[7])    ovr0 <= 1'b0;
            if (wr0_mbox && full1 && !bus.RD1) ovr1 <= 1'b1;
            else if (wr1_irq && bus.OD1[7])    ovr1 <= 1'b0;
        end
    end
`else
    assign ovr0 = 1'b0;
    assign ovr1 = 1'b0;
`endif

    // Status bytes are plain views of the flag flops.
    always_comb begin
        stat0              = 8'h00;
        stat0[ST_FULL_IN]  = full0;
        stat0[ST_FULL_OUT] = full1;
        stat0[ST_OVR]      = ovr0;
        stat0[ST_IEN]      = ie0;
        stat1              = 8'h00;
        stat1[ST_FULL_IN]  = full1;
        stat1[ST_FULL_OUT] = full0;
        stat1[ST_OVR]      = ovr1;
        stat1[ST_IEN]      = ie1;
    end

    assign bus.MBX0  = mbx0;
    assign bus.MBX1  = mbx1;
    assign bus.STAT0 = stat0;
    assign bus.STAT1 = stat1;
    assign bus.IRQ0  = full0 & ie0;
    assign bus.IRQ1  = full1 & ie1;

    ninjakun_coin_pulse #(
        .COIN_PULSE (COIN_PULSE),
        .CPW        (CPW)
    ) u_coin0 (
        .OUTCL (OUTCL),
        .RESET (RESET),
        .trig  (wr0_coin & bus.OD0[0]),
        .coin  (COIN[0])
    );

    ninjakun_coin_pulse #(
        .COIN_PULSE (COIN_PULSE),
        .CPW        (CPW)
    ) u_coin1 (
        .OUTCL (OUTCL),
        .RESET (RESET),
        .trig  (wr0_coin & bus.OD0[1]),
        .coin  (COIN[1])
    );

endmodule
